msf_bit_decoder: RTL and testbench

MSF_BIT_DECODER -- requirements
Module: msf_bit_decoder

---
 rtl/msf_bit_decoder.sv | 149 ++++++++++++++
 tb/tb_msf_bit_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/msf_bit_decoder.sv
// MSF time-signal bit decoder: measures one 500 ms second window from 10 ms
// carrier samples and classifies it as minute marker, data second or error.
module msf_bit_decoder (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       carrier_i,
  output logic       bits_valid_o,
  output logic       bits_is_second_00_o,
  output logic [1:0] bits_data_o,
  output logic       bit_error_o,
  output logic       locked_o
);

  typedef enum logic [1:0] {ARMED, MEASURE, HOLDOFF} state_e;

  state_e          state_q, state_d;
  logic [7:0]      tick_cnt_q, tick_cnt_d;
  logic [4:0][3:0] win_cnt_q, win_cnt_d;
  logic            prev_q, prev_d;
  logic            seen_one_q, seen_one_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic            s00_q, s00_d;
  logic [1:0]      data_q, data_d;
  logic            locked_q, locked_d;

  logic       start;
  logic [7:0] cnt_inc;
  logic [2:0] win_idx;
  logic [3:0] w4_final;
  logic [4:0] w_off;
  logic       is_marker;
  logic       is_normal;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    win_cnt_d  = win_cnt_q;
    prev_d     = prev_q;
    seen_one_d = seen_one_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    s00_d      = s00_q;
    data_d     = data_q;
    locked_d   = locked_q;

    cnt_inc  = (tick_cnt_q == 8'd255) ? 8'd255 : tick_cnt_q + 8'd1;
    win_idx  = 3'(cnt_inc / 8'd10);
    // A start needs a real 1 sample seen since reset, not just the reset value of prev_q.
    start    = tick_i && !carrier_i && prev_q && seen_one_q;
    // The tick_cnt=49 sample still belongs to window 4, so fold it in before classifying.
    w4_final = win_cnt_q[4] + {3'b000, ~carrier_i};
    for (int w = 0; w < 4; w++) begin
      w_off[w] = (win_cnt_q[w] >= 4'd6);
    end
    w_off[4]  = (w4_final >= 4'd6);
    is_marker = &w_off;
    is_normal = w_off[0] && !w_off[3] && !w_off[4];

    if (tick_i) begin
      prev_d = carrier_i;
      if (carrier_i) begin
        seen_one_d = 1'b1;
      end
      case (state_q)
        ARMED: begin
          if (start) begin
            state_d    = MEASURE;
            tick_cnt_d = 8'd0;
            win_cnt_d  = '0;
            win_cnt_d[0] = 4'd1;
          end else begin
            tick_cnt_d = cnt_inc;
          end
        end
        MEASURE: begin
          tick_cnt_d = cnt_inc;
          for (int w = 0; w < 5; w++) begin
            if (!carrier_i && (3'(w) == win_idx)) begin
              win_cnt_d[w] = win_cnt_q[w] + 4'd1;
            end
          end
          if (tick_cnt_q == 8'd48) begin
            state_d = HOLDOFF;
            if (is_marker) begin
              valid_d  = 1'b1;
              data_d   = 2'b00;
              s00_d    = 1'b1;
              locked_d = 1'b1;
            end else if (is_normal) begin
              valid_d  = 1'b1;
              data_d   = {w_off[2], w_off[1]};
              s00_d    = 1'b0;
              locked_d = 1'b1;
            end else begin
              error_d  = 1'b1;
              locked_d = 1'b0;
            end
          end
        end
        HOLDOFF: begin
          tick_cnt_d = cnt_inc;
          if (cnt_inc == 8'd89) begin
            state_d = ARMED;
          end
        end
        default: state_d = ARMED;
      endcase
      // Lock is lost 2 s after the last second start if no new one arrived.
      if (tick_cnt_d == 8'd199 && tick_cnt_q == 8'd198) begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARMED;
      tick_cnt_q <= 8'd255;
      win_cnt_q  <= '0;
      prev_q     <= 1'b1;
      seen_one_q <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      s00_q      <= 1'b0;
      data_q     <= 2'b00;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      win_cnt_q  <= win_cnt_d;
      prev_q     <= prev_d;
      seen_one_q <= seen_one_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      s00_q      <= s00_d;
      data_q     <= data_d;
      locked_q   <= locked_d;
    end
  end

  assign bits_valid_o        = valid_q;
  assign bit_error_o         = error_q;
  assign bits_is_second_00_o = s00_q;
  assign bits_data_o         = data_q;
  assign locked_o            = locked_q;

endmodule

// File: tb/tb_msf_bit_decoder.sv
// Scoreboard bench for msf_bit_decoder: per-second expectations come from a
// window-count model of the sample pattern and are matched by a pulse monitor.
module tb_msf_bit_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_i;
  logic       carrier_i;
  logic       bits_valid_o;
  logic       bits_is_second_00_o;
  logic [1:0] bits_data_o;
  logic       bit_error_o;
  logic       locked_o;

  msf_bit_decoder dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .tick_i              (tick_i),
    .carrier_i           (carrier_i),
    .bits_valid_o        (bits_valid_o),
    .bits_is_second_00_o (bits_is_second_00_o),
    .bits_data_o         (bits_data_o),
    .bit_error_o         (bit_error_o),
    .locked_o            (locked_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       tick;
    bit       err;
    bit [1:0] data;
    bit       s00;
    bit       locked;
  } exp_t;

  exp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       tick_num = 0;
  bit       pat[50];
  bit [1:0] mdl_data = 2'b00;
  bit       mdl_s00 = 1'b0;
  bit       mdl_locked = 1'b0;

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Pulse monitor: every valid/error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bits_valid_o === 1'b1 || bit_error_o === 1'b1)) begin
      checks++;
      if (bits_valid_o && bit_error_o) begin
        errors++;
        $display("FAIL pulse_both: valid and error together at tick %0d", tick_num);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b at tick %0d, none expected",
                 bits_valid_o, bit_error_o, tick_num);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (tick_num != e.tick || bit_error_o != e.err || bits_data_o != e.data ||
            bits_is_second_00_o != e.s00 || locked_o != e.locked) begin
          errors++;
          $display("FAIL pulse: tick=%0d err=%0b data=%0b s00=%0b lock=%0b, expected tick=%0d err=%0b data=%0b s00=%0b lock=%0b",
                   tick_num, bit_error_o, bits_data_o, bits_is_second_00_o, locked_o,
                   e.tick, e.err, e.data, e.s00, e.locked);
        end
      end
    end
  end

  task automatic send_tick(input bit c);
    @(posedge clk);
    #1;
    tick_num++;
    tick_i    = 1'b1;
    carrier_i = c;
    @(posedge clk);
    #1;
    tick_i    = 1'b0;
    carrier_i = 1'($urandom);
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 50; i++) pat[i] = 1'b1;
  endtask

  task automatic set_off(input int a, input int b);
    for (int i = a; i <= b; i++) pat[i] = 1'b0;
  endtask

  // Reference: count off samples per 100 ms window and apply the MSF bit rules.
  task automatic predict(input int sample49_tick);
    int   zeros[5];
    bit   off[5];
    exp_t e;
    for (int w = 0; w < 5; w++) zeros[w] = 0;
    for (int i = 0; i < 50; i++) if (!pat[i]) zeros[i / 10]++;
    for (int w = 0; w < 5; w++) off[w] = (zeros[w] >= 6);
    e.tick = sample49_tick;
    e.err  = 1'b1;
    if (off[0] && off[3] && off[4] && off[1] && off[2]) begin
      e.err = 1'b0; mdl_data = 2'b00; mdl_s00 = 1'b1;
    end else if (off[0] && !off[3] && !off[4]) begin
      e.err = 1'b0; mdl_data = {off[2], off[1]}; mdl_s00 = 1'b0;
    end
    mdl_locked = !e.err;
    e.data   = mdl_data;
    e.s00    = mdl_s00;
    e.locked = mdl_locked;
    exp_q.push_back(e);
  endtask

  task automatic run_second(input int lead);
    pat[0] = 1'b0;
    repeat (lead) send_tick(1'b1);
    predict(tick_num + 50);
    for (int i = 0; i < 50; i++) send_tick(pat[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check1({tag, "_valid"}, 8'(bits_valid_o), 8'd0);
    check1({tag, "_error"}, 8'(bit_error_o), 8'd0);
    check1({tag, "_s00"}, 8'(bits_is_second_00_o), 8'd0);
    check1({tag, "_data"}, 8'(bits_data_o), 8'd0);
    check1({tag, "_locked"}, 8'(locked_o), 8'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    tick_i    = 1'b0;
    carrier_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    clear_pat(); set_off(0, 9);   run_second(45);
    clear_pat(); set_off(0, 19);  run_second(45);
    clear_pat(); set_off(0, 29);  run_second(45);
    clear_pat(); set_off(0, 9); set_off(20, 29); run_second(45);
    clear_pat(); set_off(0, 49);  run_second(45);
    clear_pat(); set_off(0, 39);  run_second(45);
    clear_pat(); set_off(0, 9); pat[2] = 1'b1; pat[4] = 1'b1; pat[6] = 1'b1; run_second(45);
    clear_pat();                  run_second(45);

    // Valid second, ignored edge at tick_cnt 60, then lock timeout at 199.
    clear_pat(); set_off(0, 9);   run_second(45);
    for (int i = 50; i <= 198; i++) send_tick(i != 60);
    check1("locked_at_198", 8'(locked_o), 8'd1);
    send_tick(1'b1);
    check1("locked_after_199", 8'(locked_o), 8'd0);
    mdl_locked = 1'b0;

    // Abort a 30-off second at tick_cnt 30 after a valid one left outputs non-zero.
    clear_pat(); set_off(0, 29);  run_second(45);
    clear_pat(); set_off(0, 29);
    repeat (45) send_tick(1'b1);
    for (int i = 0; i <= 30; i++) send_tick(pat[i]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_data = 2'b00; mdl_s00 = 1'b0; mdl_locked = 1'b0;
    // Zeros straight after reset must not count as a second start.
    repeat (3) send_tick(1'b0);
    for (int i = 31; i < 50; i++) send_tick(pat[i]);
    clear_pat(); set_off(0, 19);  run_second(45);

    for (int n = 0; n < 20; n++) begin
      int tmpl;
      clear_pat();
      tmpl = $urandom_range(0, 5);
      case (tmpl)
        0: set_off(0, 9);
        1: set_off(0, 19);
        2: set_off(0, 29);
        3: begin set_off(0, 9); set_off(20, 29); end
        4: set_off(0, 49);
        default: set_off(0, 39);
      endcase
      for (int i = 1; i < 50; i++) if ($urandom_range(0, 19) == 0) pat[i] = ~pat[i];
      run_second($urandom_range(41, 120));
    end

    repeat (10) @(posedge clk);
    check1("pending_expectations", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
